// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC and the
// chip enable of the combinational instruction ROM. Applies branch redirects
// from ID and flush redirects from the exception path. A one-deep pending
// register remembers a branch that resolved while IF was stalled. Fetched
// words are registered, together with their PC, into the IF/ID latch.
//
// Ports:
//   clk           in   pipeline clock, rising edge
//   rst           in   synchronous reset, active-low
//   stall_if      in   hold the PC
//   stall_id      in   hold the IF/ID latch (implies a PC hold as well)
//   branch_flag   in   ID resolved a taken branch/jump this cycle
//   branch_target in   taken-branch destination
//   flush         in   exception/flush redirect
//   flush_pc      in   handler/return address for flush
//   rom_inst      in   instruction word returned by the ROM for rom_addr
//   rom_ce        out  ROM chip enable (registered)
//   rom_addr      out  fetch address, equal to the current PC (registered)
//   id_pc         out  IF/ID latched PC
//   id_inst       out  IF/ID latched instruction
//   id_valid      out  IF/ID latch holds a real instruction
//   pend_valid    out  a redirect is pending
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INST_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_0000,
    parameter int unsigned          PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic [INST_W-1:0] rom_inst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic              pend_valid
);

    logic              rom_ce_q,      rom_ce_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic              pend_valid_q,  pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic [ADDR_W-1:0] id_pc_q,       id_pc_d;
    logic [INST_W-1:0] id_inst_q,     id_inst_d;
    logic              id_valid_q,    id_valid_d;

    // An ID stall without an IF stall is illegal; treat it as a full stall so
    // the PC can never run ahead of a held IF/ID latch.
    logic pc_hold_s;
    assign pc_hold_s = stall_if | stall_id;

    // PC, chip enable and pending-redirect next-state.
    always_comb begin
        rom_ce_d      = 1'b1;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (rom_ce_q) begin
            if (flush) begin
                pc_d         = flush_pc;
                pend_valid_d = 1'b0;
            end else if (branch_flag && pc_hold_s) begin
                // Newer branch overwrites an older pending one.
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target;
            end else if (branch_flag) begin
                pc_d         = branch_target;
                pend_valid_d = 1'b0;
            end else if (pc_hold_s) begin
                pc_d = pc_q;
            end else if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else begin
                // Natural modulo-2^ADDR_W wrap.
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
        end else begin
            // Start-up edge: enable the ROM, keep PC at RESET_PC.
            pc_d = pc_q;
        end
    end

    // IF/ID latch next-state.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_pc_d    = {ADDR_W{1'b0}};
            id_inst_d  = {INST_W{1'b0}};
            id_valid_d = 1'b0;
        end else if (stall_if && !stall_id) begin
            // ID keeps draining while IF is held: feed it a bubble.
            id_pc_d    = {ADDR_W{1'b0}};
            id_inst_d  = {INST_W{1'b0}};
            id_valid_d = 1'b0;
        end else if (stall_id) begin
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            id_valid_d = id_valid_q;
        end else begin
            // The delay-slot instruction also takes this path.
            id_pc_d    = pc_q;
            id_inst_d  = rom_inst;
            id_valid_d = rom_ce_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_ce_q      <= 1'b0;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= {ADDR_W{1'b0}};
            id_pc_q       <= {ADDR_W{1'b0}};
            id_inst_q     <= {INST_W{1'b0}};
            id_valid_q    <= 1'b0;
        end else begin
            rom_ce_q      <= rom_ce_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
        end
    end

    assign rom_ce     = rom_ce_q;
    assign rom_addr   = pc_q;
    assign id_pc      = id_pc_q;
    assign id_inst    = id_inst_q;
    assign id_valid   = id_valid_q;
    assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Scoreboard bench for if_fetch_stage. The stimulus process drives inputs on
// the falling edge, advances a behavioural model of the stage and queues the
// outputs expected after the next rising edge. An independent monitor pops
// one entry per rising edge and compares. Directed scenarios are followed by
// randomized traffic.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        pend;
        logic [31:0] ptgt;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        id_valid;
    } state_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] rom_inst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        pend_valid;

    int     n_checks = 0;
    int     n_fail   = 0;
    state_t model;
    state_t exp_q[$];

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .flush_pc(flush_pc), .rom_inst(rom_inst),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .id_pc(id_pc),
        .id_inst(id_inst), .id_valid(id_valid), .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    // ROM contents: an address-dependent scramble so every word is distinct.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage holds after one rising edge.
    function automatic state_t next_state(input state_t s);
        state_t n = s;
        logic   held = stall_if | stall_id;
        if (!rst) begin
            n = '{ce: 1'b0, pc: 32'h0, pend: 1'b0, ptgt: 32'h0,
                  id_pc: 32'h0, id_inst: 32'h0, id_valid: 1'b0};
            return n;
        end
        n.ce = 1'b1;
        if (s.ce) begin
            if (flush) begin
                n.pc = flush_pc; n.pend = 1'b0;
            end else if (branch_flag) begin
                if (held) begin
                    n.pend = 1'b1; n.ptgt = branch_target;
                end else begin
                    n.pc = branch_target; n.pend = 1'b0;
                end
            end else if (!held) begin
                n.pc   = s.pend ? s.ptgt : s.pc + 32'd4;
                n.pend = 1'b0;
            end
        end
        if (flush || (stall_if && !stall_id)) begin
            n.id_pc = 32'h0; n.id_inst = 32'h0; n.id_valid = 1'b0;
        end else if (!stall_id) begin
            n.id_pc = s.pc; n.id_inst = rom_word(s.pc); n.id_valid = s.ce;
        end
        return n;
    endfunction

    // One cycle of stimulus: drive, predict, queue, then wait past the monitor.
    task automatic cyc(input logic r, input logic sif, input logic sid,
                       input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] fp);
        @(negedge clk);
        rst = r; stall_if = sif; stall_id = sid;
        branch_flag = br; branch_target = bt; flush = fl; flush_pc = fp;
        model = next_state(model);
        exp_q.push_back(model);
        @(posedge clk);
        #2;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: compare DUT outputs with the oldest expectation after each edge.
    initial begin
        state_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rom_ce",     {31'h0, rom_ce},     {31'h0, e.ce});
                check("rom_addr",   rom_addr,            e.pc);
                check("pend_valid", {31'h0, pend_valid}, {31'h0, e.pend});
                check("id_pc",      id_pc,               e.id_pc);
                check("id_inst",    id_inst,             e.id_inst);
                check("id_valid",   {31'h0, id_valid},   {31'h0, e.id_valid});
            end
        end
    end

    initial begin
        model = '{ce: 1'b0, pc: 32'h0, pend: 1'b0, ptgt: 32'h0,
                  id_pc: 32'h0, id_inst: 32'h0, id_valid: 1'b0};

        // Reset and start-up.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_ce", {31'h0, rom_ce}, 32'h0);
        check("rst_addr", rom_addr, 32'h0);
        seq(1);
        check("start_ce", {31'h0, rom_ce}, 32'h1);
        check("start_addr", rom_addr, 32'h0);
        seq(1);
        check("e2_addr", rom_addr, 32'h4);
        check("e2_idvalid", {31'h0, id_valid}, 32'h1);
        seq(1);
        check("e3_addr", rom_addr, 32'h8);
        check("e3_idpc", id_pc, 32'h4);
        seq(2);
        check("at_10", rom_addr, 32'h10);

        // Branch without stall: delay slot at 0x10 goes to ID.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        check("br_addr", rom_addr, 32'h100);
        check("br_delay_pc", id_pc, 32'h10);
        check("br_delay_inst", id_inst, rom_word(32'h10));
        check("br_delay_valid", {31'h0, id_valid}, 32'h1);

        // Sequential wrap.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        seq(1);
        check("wrap_fc", rom_addr, 32'hFFFF_FFFC);
        seq(1);
        check("wrap_0", rom_addr, 32'h0);
        check("wrap_idpc", id_pc, 32'hFFFF_FFFC);

        // Branch under stall.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        check("at_20", rom_addr, 32'h20);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
        check("pend_set", {31'h0, pend_valid}, 32'h1);
        check("pend_hold_addr", rom_addr, 32'h20);
        check("bubble1", {31'h0, id_valid}, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("bubble2", {31'h0, id_valid}, 32'h0);
        check("pend_hold2", rom_addr, 32'h20);
        seq(1);
        check("rel_addr", rom_addr, 32'h200);
        check("rel_idpc", id_pc, 32'h20);
        check("rel_pend", {31'h0, pend_valid}, 32'h0);

        // Flush beats branch and stall.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h180);
        check("fl_addr", rom_addr, 32'h180);
        check("fl_pend", {31'h0, pend_valid}, 32'h0);
        check("fl_valid", {31'h0, id_valid}, 32'h0);
        check("fl_inst", id_inst, 32'h0);

        // stall_id hold with a pending branch, then reset mid-stall.
        seq(2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h440, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            check("sid_addr", rom_addr, 32'h188);
            check("sid_idpc", id_pc, 32'h184);
            check("sid_inst", id_inst, rom_word(32'h184));
        end
        check("sid_pend", {31'h0, pend_valid}, 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600);
        check("mrst_ce", {31'h0, rom_ce}, 32'h0);
        check("mrst_addr", rom_addr, 32'h0);
        check("mrst_pend", {31'h0, pend_valid}, 32'h0);
        check("mrst_idpc", id_pc, 32'h0);
        check("mrst_valid", {31'h0, id_valid}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, sif, sid, br, fl;
            r   = ($urandom_range(0, 63) != 0);
            sif = ($urandom_range(0, 3) == 0);
            sid = sif ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            br  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            cyc(r, sif, sid, br, {$urandom_range(0, 32'h3FFF), 2'b00} & 32'hFFFF_FFFC,
                fl, $urandom() & 32'hFFFF_FFFC);
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
